// File: rtl/energy_meter_pkg.sv
// rtl/energy_meter_pkg.sv - shared level codes and arbiter state encodings
package energy_meter_pkg;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        LVL_LOW  = 2'd1,
        LVL_MED  = 2'd2,
        LVL_CRIT = 2'd3
    } level_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/energy_channel.sv
// rtl/energy_channel.sv - per-channel edge detect, saturating counter, level and sat flag
module energy_channel
    import energy_meter_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TH_LOW  = 10,
    parameter int TH_MED  = 50,
    parameter int TH_HIGH = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       level,
    output logic             sat,
    output logic             level_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TH_L    = CNT_W'(TH_LOW);
    localparam logic [CNT_W-1:0] TH_M    = CNT_W'(TH_MED);
    localparam logic [CNT_W-1:0] TH_H    = CNT_W'(TH_HIGH);

    logic   prev;
    logic   edge_det;
    level_t level_d;

    assign edge_det = pulse & ~prev;

    always_comb begin
        level_d = LVL_CRIT;
        if (count < TH_L)
            level_d = LVL_NONE;
        else if (count < TH_M)
            level_d = LVL_LOW;
        else if (count < TH_H)
            level_d = LVL_MED;
    end

    // Qualified by the top against clear; the level register is the one being compared.
    assign level_rise = (2'(level_d) > level);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev  <= 1'b0;
            count <= '0;
            level <= 2'(LVL_NONE);
            sat   <= 1'b0;
        end else begin
            prev <= pulse;
            if (clr) begin
                count <= '0;
                level <= 2'(LVL_NONE);
                sat   <= 1'b0;
            end else begin
                level <= 2'(level_d);
                if (edge_det) begin
                    if (count == CNT_MAX)
                        sat <= 1'b1;
                    else
                        count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/energy_alert_engine.sv
// rtl/energy_alert_engine.sv - metered channels with round-robin alert message arbiter
module energy_alert_engine
    import energy_meter_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int TH_LOW  = 10,
    parameter int TH_MED  = 50,
    parameter int TH_HIGH = 100,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       pulse_in,
    input  logic [NUM_CH-1:0]       clr_ch,
    output logic                    msg_valid,
    input  logic                    msg_ready,
    output logic [CH_W-1:0]         msg_ch,
    output logic [CNT_W-1:0]        msg_units,
    output logic [1:0]              msg_level,
    output logic [NUM_CH*CNT_W-1:0] energy_flat,
    output logic [2*NUM_CH-1:0]     level_flat,
    output logic [NUM_CH-1:0]       sat
);

    logic [CNT_W-1:0]  count [NUM_CH];
    logic [1:0]        level [NUM_CH];
    logic [NUM_CH-1:0] level_rise;
    logic [NUM_CH-1:0] pending;

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_found;
    logic              grant_take;
    logic              handshake;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        energy_channel #(
            .CNT_W   (CNT_W),
            .TH_LOW  (TH_LOW),
            .TH_MED  (TH_MED),
            .TH_HIGH (TH_HIGH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .pulse      (pulse_in[g]),
            .clr        (clr_ch[g]),
            .count      (count[g]),
            .level      (level[g]),
            .sat        (sat[g]),
            .level_rise (level_rise[g])
        );
        assign energy_flat[g*CNT_W +: CNT_W] = count[g];
        assign level_flat[2*g +: 2]          = level[g];
    end

    // Search starts one past the last granted channel so every pending channel is served in turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!grant_found && pending[CH_W'((int'(rr_ptr) + i) % NUM_CH)]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    grant_take = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (msg_ready) begin
                    handshake = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    assign msg_valid = (state_q == ST_SEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_ch    <= '0;
            msg_units <= '0;
            msg_level <= '0;
            rr_ptr    <= CH_W'(NUM_CH - 1);
        end else begin
            if (grant_take) begin
                msg_ch    <= grant_idx;
                msg_units <= count[grant_idx];
                msg_level <= level[grant_idx];
            end
            if (handshake)
                rr_ptr <= msg_ch;
        end
    end

    // A new rise beats the grant-clear, so an increase landing on the grant cycle is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_ch[i])
                    pending[i] <= 1'b0;
                else if (level_rise[i])
                    pending[i] <= 1'b1;
                else if (grant_take && grant_idx == CH_W'(i))
                    pending[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_energy_alert_engine.sv
// tb/tb_energy_alert_engine.sv - directed self-checking bench for energy_alert_engine
module tb_energy_alert_engine;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  pulse_in, clr_ch;
    logic        msg_ready, msg_valid;
    logic [1:0]  msg_ch, msg_level;
    logic [15:0] msg_units;
    logic [63:0] energy_flat;
    logic [7:0]  level_flat;
    logic [3:0]  sat;

    logic [3:0]  pulse4, clr4;
    logic        ready4, valid4;
    logic [1:0]  ch4, lvl4;
    logic [3:0]  units4;
    logic [15:0] energy4;
    logic [7:0]  level4;
    logic [3:0]  sat4;

    int n_checks = 0;
    int n_fail   = 0;
    int waited;
    int k;
    logic [6:0] exp_v = 7'b0101010;
    int exp_ch [3] = '{0, 2, 3};

    always #5 clk = ~clk;

    energy_alert_engine #(
        .NUM_CH(4), .CNT_W(16), .TH_LOW(2), .TH_MED(4), .TH_HIGH(6)
    ) dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .clr_ch(clr_ch),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_ch(msg_ch),
        .msg_units(msg_units), .msg_level(msg_level),
        .energy_flat(energy_flat), .level_flat(level_flat), .sat(sat)
    );

    energy_alert_engine #(
        .NUM_CH(4), .CNT_W(4), .TH_LOW(2), .TH_MED(4), .TH_HIGH(6)
    ) dut4 (
        .clk(clk), .reset(reset), .pulse_in(pulse4), .clr_ch(clr4),
        .msg_valid(valid4), .msg_ready(ready4), .msg_ch(ch4),
        .msg_units(units4), .msg_level(lvl4),
        .energy_flat(energy4), .level_flat(level4), .sat(sat4)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_mask(input logic [3:0] mask, input int n);
        repeat (n) begin
            pulse_in = mask;
            step(1);
            pulse_in = '0;
            step(1);
        end
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!msg_valid && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1; pulse_in = '0; clr_ch = '0; msg_ready = 1'b0;
        pulse4 = '0; clr4 = '0; ready4 = 1'b1;
        step(2);
        check("rst_valid",  msg_valid,   1'b0);
        check("rst_energy", energy_flat, 64'h0);
        check("rst_level",  level_flat,  8'h0);
        check("rst_sat",    sat,         4'h0);
        check("rst_msg",    {msg_ch, msg_units, msg_level}, 20'h0);
        reset = 1'b0;

        // two pulses on ch1 -> single level-1 message
        msg_ready = 1'b1;
        step(1);
        pulse_mask(4'b0010, 2);
        wait_valid(20, waited);
        check("t1_latency", waited, 1);
        check("t1_valid", msg_valid, 1'b1);
        check("t1_msg", {msg_ch, msg_units, msg_level}, {2'd1, 16'd2, 2'd1});
        check("t1_energy", energy_flat[16 +: 16], 16'd2);
        step(1);
        check("t1_one_cycle", msg_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t1_no_more", msg_valid, 1'b0);
        end

        // three channels crossing TH_LOW together, served 0,2,3 with gaps
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        pulse_mask(4'b1101, 2);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            check("t2_valid", msg_valid, exp_v[i]);
            if (exp_v[i]) begin
                check("t2_msg", {msg_ch, msg_units, msg_level}, {2'(exp_ch[k]), 16'd2, 2'd1});
                k++;
            end
            step(1);
        end

        // back-pressure while ch1 climbs to 6 units
        msg_ready = 1'b0;
        pulse_mask(4'b0010, 2);
        wait_valid(20, waited);
        check("t3_latency", waited, 1);
        check("t3_first", {msg_valid, msg_ch, msg_units, msg_level}, {1'b1, 2'd1, 16'd2, 2'd1});
        for (int i = 0; i < 10; i++) begin
            pulse_in[1] = (i % 2 == 0) && (i < 8);
            step(1);
            check("t3_hold", {msg_valid, msg_ch, msg_units, msg_level}, {1'b1, 2'd1, 16'd2, 2'd1});
        end
        pulse_in = '0;
        check("t3_energy", energy_flat[16 +: 16], 16'd6);
        msg_ready = 1'b1;
        step(1);
        check("t3_after_hs", msg_valid, 1'b0);
        step(1);
        check("t3_second", {msg_valid, msg_ch, msg_units, msg_level}, {1'b1, 2'd1, 16'd6, 2'd3});
        step(1);
        check("t3_done", msg_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t3_quiet", msg_valid, 1'b0);
        end

        // clear beats a same-cycle rising pulse on ch0
        check("t4_pre", energy_flat[0 +: 16], 16'd2);
        clr_ch[0] = 1'b1;
        pulse_in[0] = 1'b1;
        step(1);
        clr_ch[0] = 1'b0;
        check("t4_cleared", energy_flat[0 +: 16], 16'd0);
        check("t4_level", level_flat[1:0], 2'd0);
        step(1);
        check("t4_no_edge", energy_flat[0 +: 16], 16'd0);
        pulse_in = '0;
        step(2);
        check("t4_no_msg", msg_valid, 1'b0);

        // reset aborts an in-flight message
        msg_ready = 1'b0;
        pulse_mask(4'b0100, 2);
        wait_valid(20, waited);
        check("t5_msg", {msg_valid, msg_ch, msg_units, msg_level}, {1'b1, 2'd2, 16'd4, 2'd2});
        reset = 1'b1;
        step(1);
        check("t5_valid", msg_valid, 1'b0);
        check("t5_msg_zero", {msg_ch, msg_units, msg_level}, 20'h0);
        check("t5_energy", energy_flat, 64'h0);
        check("t5_level", {level_flat, sat}, 12'h0);
        reset = 1'b0;
        step(1);

        // 4-bit counter saturation and clear on ch2
        for (int i = 0; i < 17; i++) begin
            pulse4[2] = 1'b1;
            step(1);
            pulse4[2] = 1'b0;
            step(1);
        end
        step(1);
        check("t6_count", energy4[8 +: 4], 4'd15);
        check("t6_sat", sat4, 4'b0100);
        check("t6_level", level4[4 +: 2], 2'd3);
        clr4[2] = 1'b1;
        step(1);
        clr4[2] = 1'b0;
        check("t6_clr", {energy4[8 +: 4], level4[4 +: 2], sat4[2]}, 7'h0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t6_no_msg", valid4, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
